parity_frame_receiver: RTL and testbench
========================================

// Module: parity_frame_receiver
// PURPOSE
// - Serial receive end of the parity-protected byte link. The transmit side
//   appends an XOR-reduction parity bit to each byte.
// - Deserializes DATA_WIDTH data bits (LSB first) plus one parity bit.
// - Recomputes ^data, compares it against the received parity bit, and
//   publishes the byte with its &/|/^ reduction flags.
// - Sits between the serial link sampler and the byte consumer.
// PARAMETERS
// - DATA_WIDTH  8  data bits per frame, >=2; the parity bit follows the data.
// - ODD_PARITY  0  0: expected parity = ^data; 1: expected parity = ~^data.
// PORTS
// - clk           in   1           single clock, rising edge
// - rst           in   1           synchronous, active-high reset
// - bit_valid     in   1           bit_in is sampled on this cycle
// - bit_in        in   1           serial data/parity bit
// - frame_abort   in   1           discard the partial frame, restart at bit 0
// - frame_valid   out  1           one-cycle pulse: new frame results valid
// - data_out      out  DATA_WIDTH  last completed byte, bit0 = first bit received
// - parity_error  out  1           received parity != expected (valid with data_out)
// - all_ones      out  1           &data_out
// - any_one       out  1           |data_out
// - busy          out  1           partial frame in progress (bit count > 0)
// BEHAVIOUR
// - Reset is synchronous, active-high, on clk; it dominates all other inputs.
// - Reset values:
//   - frame_valid, parity_error, all_ones, any_one, busy = 0
//   - data_out = 0
//   - state = S_DATA, bit_idx = 0, shift register = 0
// - FSM states: S_DATA, S_PARITY.
//   - S_DATA: on bit_valid, shift[bit_idx] <= bit_in and bit_idx++.
//     At bit_idx == DATA_WIDTH-1, go to S_PARITY.
//   - S_PARITY: on bit_valid, latch the outputs, pulse frame_valid on the
//     next cycle, clear bit_idx, return to S_DATA.
// - Latency: frame_valid rises on the clk edge that samples the parity bit,
//   so it is visible in the cycle after that bit. It lasts exactly 1 cycle.
// - Output hold: data_out, parity_error, all_ones and any_one are registered.
//   They change only when frame_valid asserts and hold until the next frame.
// - Flag sources: all_ones, any_one and expected parity come from the
//   assembled byte, not from a running accumulator. Width is DATA_WIDTH;
//   there is no truncation.
// - Back-to-back frames: a data bit may arrive in the same cycle frame_valid
//   is high. It is accepted as bit 0 of the next frame.
// - Gaps: bit_valid=0 is a stall of any length. State and bit_idx hold.
// - frame_abort:
//   - Returns the FSM to S_DATA with bit_idx=0 on the next edge.
//   - No frame_valid pulse; the outputs keep their previous frame values.
// - Abort with bit_valid in the same cycle: abort wins and the bit is
//   dropped. This includes the parity bit, so no frame completes.
// - Abort while idle (bit_idx=0, S_DATA) has no effect.
// - Reset mid-frame: the partial frame is discarded and the outputs clear
//   to their reset values.
// - busy = (state==S_PARITY) || (bit_idx != 0).
// CONFIGURATION
// - Macro PARITY_ERR_COUNT_EN.
// - Defined: adds output port err_count [7:0].
//   - Reset value 0.
//   - Increments on each frame_valid with parity_error=1.
//   - Saturates at 8'hFF; it does not wrap.
//   - Aborted frames are not counted.
// - Undefined: the port and counter do not exist; all else is identical.
// TESTING
// - Good frame: rst for 2 cycles, then bits 0,1,0,0,1,0,1,1 (=8'hD2) and
//   parity 0 -> data_out=8'hD2, parity_error=0, all_ones=0, any_one=1,
//   frame_valid high exactly 1 cycle.
// - Bad parity: same bits with parity 1 -> data_out=8'hD2, parity_error=1.
//   If PARITY_ERR_COUNT_EN: err_count=1.
// - All-ones byte with stalls: 8'hFF with 3-cycle bit_valid gaps, parity 0
//   -> all_ones=1, any_one=1, parity_error=0, frame_valid only after bit 9.
// - Abort at bit 5 of 8'h0F, then a full 8'h00 frame with parity 0 ->
//   no pulse at the abort; next pulse gives data_out=8'h00, any_one=0.
// - Abort coincident with the parity bit: no pulse and busy=0.
//   Back-to-back 8'h01/8'h80 frames (parity 1 each) -> two pulses, 9 cycles apart.
// - Mid-frame reset: rst after 4 bits -> busy=0, data_out=0.
//   A following 8'h3C frame (parity 0) is received correctly.
// - Saturation (macro on): 260 bad-parity frames -> err_count=8'hFF.

Source files
------------

// File: rtl/parity_frame_if.sv
`default_nettype none
// ============================================================================
// Module      : parity_frame_if
// Description : Link bundle between the serial bit sampler and the parity
//               frame receiver.
//               master : bit sampler side. Drives bit_valid, bit_in and
//                        frame_abort; observes the frame results.
//               slave  : receiver side. Observes the serial inputs and drives
//                        frame_valid, data_out, parity_error, all_ones,
//                        any_one and busy, plus err_count when
//                        PARITY_ERR_COUNT_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
interface parity_frame_if #(
   parameter int DATA_WIDTH = 8
);
   logic                  bit_valid;
   logic                  bit_in;
   logic                  frame_abort;
   logic                  frame_valid;
   logic [DATA_WIDTH-1:0] data_out;
   logic                  parity_error;
   logic                  all_ones;
   logic                  any_one;
   logic                  busy;
`ifdef PARITY_ERR_COUNT_EN
   logic [7:0]            err_count;

   modport master (
      output bit_valid, bit_in, frame_abort,
      input  frame_valid, data_out, parity_error, all_ones, any_one, busy,
             err_count
   );

   modport slave (
      input  bit_valid, bit_in, frame_abort,
      output frame_valid, data_out, parity_error, all_ones, any_one, busy,
             err_count
   );
`else
   modport master (
      output bit_valid, bit_in, frame_abort,
      input  frame_valid, data_out, parity_error, all_ones, any_one, busy
   );

   modport slave (
      input  bit_valid, bit_in, frame_abort,
      output frame_valid, data_out, parity_error, all_ones, any_one, busy
   );
`endif
endinterface : parity_frame_if
`default_nettype wire

// File: rtl/parity_frame_receiver.sv
`default_nettype none
// ============================================================================
// Module      : parity_frame_receiver
// Description : Receive end of the parity-protected serial byte link.
//               Collects DATA_WIDTH data bits (LSB first), then one parity
//               bit. It checks the parity against the assembled byte and
//               publishes the byte with its AND/OR reduction flags. Results
//               are announced by a one-cycle frame_valid pulse.
// Ports       : clk  - rising-edge clock
//               rst  - synchronous active-high reset
//               link - parity_frame_if.slave
//                      in : bit_valid, bit_in, frame_abort
//                      out: frame_valid, data_out, parity_error,
//                           all_ones, any_one, busy [, err_count]
// Parameters  : DATA_WIDTH (>=2) data bits per frame
//               ODD_PARITY  0: expected = ^data, 1: expected = ~^data
// Config      : PARITY_ERR_COUNT_EN - when defined, adds an 8-bit
//               saturating count of parity-error frames (err_count).
// Revision    : 1.0 - initial release
// ============================================================================
module parity_frame_receiver #(
   parameter int DATA_WIDTH = 8,
   parameter int ODD_PARITY = 0
) (
   input  wire            clk,
   input  wire            rst,
   parity_frame_if.slave  link
);

   localparam int                IDX_W    = $clog2(DATA_WIDTH);
   localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(DATA_WIDTH - 1);
   localparam logic              ODD_BIT  = (ODD_PARITY != 0);

   typedef enum logic [0:0] {
      S_DATA   = 1'b0,
      S_PARITY = 1'b1
   } state_t;

   state_t                state_q,        state_d;
   logic [IDX_W-1:0]      bit_idx_q,      bit_idx_d;
   logic [DATA_WIDTH-1:0] shift_q,        shift_d;
   logic                  frame_valid_q,  frame_valid_d;
   logic [DATA_WIDTH-1:0] data_out_q,     data_out_d;
   logic                  parity_error_q, parity_error_d;
   logic                  all_ones_q,     all_ones_d;
   logic                  any_one_q,      any_one_d;
   logic                  exp_parity;
`ifdef PARITY_ERR_COUNT_EN
   logic [7:0]            err_count_q,    err_count_d;
`endif

   // Parity is taken from the fully assembled byte, which is complete once
   // the FSM sits in S_PARITY.
   assign exp_parity = (^shift_q) ^ ODD_BIT;

   always_comb begin
      state_d        = state_q;
      bit_idx_d      = bit_idx_q;
      shift_d        = shift_q;
      frame_valid_d  = 1'b0;
      data_out_d     = data_out_q;
      parity_error_d = parity_error_q;
      all_ones_d     = all_ones_q;
      any_one_d      = any_one_q;
`ifdef PARITY_ERR_COUNT_EN
      err_count_d    = err_count_q;
`endif

      // Abort has priority over a coincident bit, including the parity bit,
      // so an aborted frame never produces results.
      if (link.frame_abort) begin
         state_d   = S_DATA;
         bit_idx_d = '0;
      end else if (link.bit_valid) begin
         case (state_q)
            S_DATA: begin
               shift_d[bit_idx_q] = link.bit_in;
               if (bit_idx_q == LAST_IDX) begin
                  // busy stays high through S_PARITY via the state term.
                  state_d   = S_PARITY;
                  bit_idx_d = '0;
               end else begin
                  bit_idx_d = bit_idx_q + 1'b1;
               end
            end
            S_PARITY: begin
               frame_valid_d  = 1'b1;
               data_out_d     = shift_q;
               parity_error_d = (link.bit_in != exp_parity);
               all_ones_d     = &shift_q;
               any_one_d      = |shift_q;
`ifdef PARITY_ERR_COUNT_EN
               if ((link.bit_in != exp_parity) && (err_count_q != 8'hFF)) begin
                  err_count_d = err_count_q + 8'd1;
               end
`endif
               state_d   = S_DATA;
               bit_idx_d = '0;
            end
            default: begin
               state_d   = S_DATA;
               bit_idx_d = '0;
            end
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q        <= S_DATA;
         bit_idx_q      <= '0;
         shift_q        <= '0;
         frame_valid_q  <= 1'b0;
         data_out_q     <= '0;
         parity_error_q <= 1'b0;
         all_ones_q     <= 1'b0;
         any_one_q      <= 1'b0;
`ifdef PARITY_ERR_COUNT_EN
         err_count_q    <= 8'd0;
`endif
      end else begin
         state_q        <= state_d;
         bit_idx_q      <= bit_idx_d;
         shift_q        <= shift_d;
         frame_valid_q  <= frame_valid_d;
         data_out_q     <= data_out_d;
         parity_error_q <= parity_error_d;
         all_ones_q     <= all_ones_d;
         any_one_q      <= any_one_d;
`ifdef PARITY_ERR_COUNT_EN
         err_count_q    <= err_count_d;
`endif
      end
   end

   assign link.frame_valid  = frame_valid_q;
   assign link.data_out     = data_out_q;
   assign link.parity_error = parity_error_q;
   assign link.all_ones     = all_ones_q;
   assign link.any_one      = any_one_q;
   assign link.busy         = (state_q == S_PARITY) || (bit_idx_q != '0);
`ifdef PARITY_ERR_COUNT_EN
   assign link.err_count    = err_count_q;
`endif

endmodule : parity_frame_receiver
`default_nettype wire

// File: tb/tb_parity_frame_receiver.sv
`default_nettype none
// ============================================================================
// Module      : tb_parity_frame_receiver
// Description : Directed self-checking bench for parity_frame_receiver.
//               Inputs change 1 time unit after a rising edge; outputs are
//               checked at the same point, reflecting that edge.
//               Honours PARITY_ERR_COUNT_EN for the err_count checks.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_parity_frame_receiver;

   logic clk;
   logic rst;
   int   n_asserts;
   int   n_fail;
   int   cyc;
   int   pulses;
   int   t1;
   int   t2;
   int   p0;

   parity_frame_if #(.DATA_WIDTH(8)) link ();

   parity_frame_receiver #(
      .DATA_WIDTH (8),
      .ODD_PARITY (0)
   ) dut (
      .clk  (clk),
      .rst  (rst),
      .link (link)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // Count every frame_valid cycle, sampled mid-cycle.
   initial pulses = 0;
   always @(negedge clk) if (link.frame_valid === 1'b1) pulses <= pulses + 1;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_asserts++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic idle(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic send_bit(input logic b, input logic ab);
      link.bit_valid   = 1'b1;
      link.bit_in      = b;
      link.frame_abort = ab;
      @(posedge clk);
      #1;
      link.bit_valid   = 1'b0;
      link.bit_in      = 1'b0;
      link.frame_abort = 1'b0;
   endtask

   task automatic send_data(input logic [7:0] d, input int gap);
      for (int i = 0; i < 8; i++) begin
         send_bit(d[i], 1'b0);
         if (gap > 0) idle(gap);
      end
   endtask

   initial begin
      n_asserts        = 0;
      n_fail           = 0;
      rst              = 1'b1;
      link.bit_valid   = 1'b0;
      link.bit_in      = 1'b0;
      link.frame_abort = 1'b0;
      idle(2);

      // Reset state
      check("rst_frame_valid", 32'(link.frame_valid), 32'd0);
      check("rst_data_out", 32'(link.data_out), 32'h00);
      check("rst_parity_error", 32'(link.parity_error), 32'd0);
      check("rst_all_ones", 32'(link.all_ones), 32'd0);
      check("rst_any_one", 32'(link.any_one), 32'd0);
      check("rst_busy", 32'(link.busy), 32'd0);
`ifdef PARITY_ERR_COUNT_EN
      check("rst_err_count", 32'(link.err_count), 32'd0);
`endif
      rst = 1'b0;
      idle(1);

      // Good frame 8'hD2, parity 0
      send_data(8'hD2, 0);
      check("good_busy_pre_parity", 32'(link.busy), 32'd1);
      check("good_no_early_pulse", 32'(link.frame_valid), 32'd0);
      send_bit(1'b0, 1'b0);
      check("good_frame_valid", 32'(link.frame_valid), 32'd1);
      check("good_data_out", 32'(link.data_out), 32'hD2);
      check("good_parity_error", 32'(link.parity_error), 32'd0);
      check("good_all_ones", 32'(link.all_ones), 32'd0);
      check("good_any_one", 32'(link.any_one), 32'd1);
      check("good_busy_after", 32'(link.busy), 32'd0);
      idle(1);
      check("good_pulse_1cycle", 32'(link.frame_valid), 32'd0);
      check("good_data_hold", 32'(link.data_out), 32'hD2);
      check("good_pulse_count", 32'(pulses), 32'd1);

      // Bad parity, same byte
      send_data(8'hD2, 0);
      send_bit(1'b1, 1'b0);
      check("bad_frame_valid", 32'(link.frame_valid), 32'd1);
      check("bad_data_out", 32'(link.data_out), 32'hD2);
      check("bad_parity_error", 32'(link.parity_error), 32'd1);
`ifdef PARITY_ERR_COUNT_EN
      check("bad_err_count", 32'(link.err_count), 32'd1);
`endif
      idle(1);

      // All ones with 3-cycle stalls between bits
      p0 = pulses;
      send_data(8'hFF, 3);
      check("ff_busy_stalled", 32'(link.busy), 32'd1);
      check("ff_no_pulse_yet", 32'(pulses), 32'(p0));
      send_bit(1'b0, 1'b0);
      check("ff_frame_valid", 32'(link.frame_valid), 32'd1);
      check("ff_data_out", 32'(link.data_out), 32'hFF);
      check("ff_all_ones", 32'(link.all_ones), 32'd1);
      check("ff_any_one", 32'(link.any_one), 32'd1);
      check("ff_parity_error", 32'(link.parity_error), 32'd0);
      idle(1);
      check("ff_pulse_count", 32'(pulses), 32'(p0 + 1));

      // Abort at bit 5 of 8'h0F, then 8'h00 frame
      p0 = pulses;
      for (int i = 0; i < 5; i++) send_bit((i < 4) ? 1'b1 : 1'b0, 1'b0);
      check("abort_busy_before", 32'(link.busy), 32'd1);
      send_bit(1'b0, 1'b1);
      check("abort_busy_after", 32'(link.busy), 32'd0);
      check("abort_no_pulse", 32'(link.frame_valid), 32'd0);
      check("abort_data_hold", 32'(link.data_out), 32'hFF);
      idle(1);
      check("abort_pulse_count", 32'(pulses), 32'(p0));
      send_data(8'h00, 0);
      send_bit(1'b0, 1'b0);
      check("zero_frame_valid", 32'(link.frame_valid), 32'd1);
      check("zero_data_out", 32'(link.data_out), 32'h00);
      check("zero_any_one", 32'(link.any_one), 32'd0);
      check("zero_all_ones", 32'(link.all_ones), 32'd0);
      check("zero_parity_error", 32'(link.parity_error), 32'd0);
      idle(1);

      // Abort coincident with a (wrong) parity bit
      p0 = pulses;
      send_data(8'h55, 0);
      send_bit(1'b1, 1'b1);
      check("abpar_no_pulse", 32'(link.frame_valid), 32'd0);
      check("abpar_busy", 32'(link.busy), 32'd0);
      check("abpar_data_hold", 32'(link.data_out), 32'h00);
      idle(1);
      check("abpar_pulse_count", 32'(pulses), 32'(p0));
`ifdef PARITY_ERR_COUNT_EN
      check("abpar_err_count", 32'(link.err_count), 32'd1);
`endif

      // Back-to-back 8'h01 / 8'h80, parity 1 each
      p0 = pulses;
      send_data(8'h01, 0);
      send_bit(1'b1, 1'b0);
      t1 = cyc;
      check("b2b_first_valid", 32'(link.frame_valid), 32'd1);
      check("b2b_first_data", 32'(link.data_out), 32'h01);
      check("b2b_first_perr", 32'(link.parity_error), 32'd0);
      send_data(8'h80, 0);
      send_bit(1'b1, 1'b0);
      t2 = cyc;
      check("b2b_second_valid", 32'(link.frame_valid), 32'd1);
      check("b2b_second_data", 32'(link.data_out), 32'h80);
      check("b2b_second_perr", 32'(link.parity_error), 32'd0);
      check("b2b_spacing", 32'(t2 - t1), 32'd9);
      idle(1);
      check("b2b_pulse_count", 32'(pulses), 32'(p0 + 2));

      // Reset mid-frame, then 8'h3C
      send_bit(1'b1, 1'b0);
      send_bit(1'b0, 1'b0);
      send_bit(1'b1, 1'b0);
      send_bit(1'b0, 1'b0);
      rst = 1'b1;
      idle(1);
      rst = 1'b0;
      check("mrst_busy", 32'(link.busy), 32'd0);
      check("mrst_data_out", 32'(link.data_out), 32'h00);
      check("mrst_any_one", 32'(link.any_one), 32'd0);
`ifdef PARITY_ERR_COUNT_EN
      check("mrst_err_count", 32'(link.err_count), 32'd0);
`endif
      send_data(8'h3C, 0);
      send_bit(1'b0, 1'b0);
      check("post_rst_valid", 32'(link.frame_valid), 32'd1);
      check("post_rst_data", 32'(link.data_out), 32'h3C);
      check("post_rst_perr", 32'(link.parity_error), 32'd0);
      check("post_rst_any_one", 32'(link.any_one), 32'd1);
      check("post_rst_all_ones", 32'(link.all_ones), 32'd0);
      idle(1);

`ifdef PARITY_ERR_COUNT_EN
      // Saturation: 260 bad-parity frames of 8'h00
      for (int f = 0; f < 260; f++) begin
         send_data(8'h00, 0);
         send_bit(1'b1, 1'b0);
         if (f == 253) check("sat_err_count_254", 32'(link.err_count), 32'd254);
      end
      check("sat_parity_error", 32'(link.parity_error), 32'd1);
      check("sat_err_count", 32'(link.err_count), 32'hFF);
      idle(1);
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
      $finish;
   end

endmodule : tb_parity_frame_receiver
`default_nettype wire
